// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings,
// default latencies and the FSM state encoding.
package md_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Ops that occupy the unit for a multi-cycle busy period.
  function automatic logic isMultDiv(input logic [3:0] opIn);
    return (opIn == OP_MULT) || (opIn == OP_MULTU) ||
           (opIn == OP_DIV)  || (opIn == OP_DIVU);
  endfunction

  function automatic logic isDiv(input logic [3:0] opIn);
    return (opIn == OP_DIV) || (opIn == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational multiply/divide datapath; result is packed {hi, lo}.
// Divide-by-zero is flagged so the sequencer can suppress the commit.
module md_alu
  import md_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] result_o,
  output logic        div_by_zero_o
);

  logic signed [63:0] prodS;
  logic        [63:0] prodU;
  logic signed [31:0] aS;
  logic signed [31:0] bS;
  logic signed [31:0] quotS;
  logic signed [31:0] remS;
  logic        [31:0] quotU;
  logic        [31:0] remU;
  logic               divOverflow;
  logic               bZero;

  assign aS          = $signed(a_i);
  assign bS          = $signed(b_i);
  assign prodS       = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign prodU       = {32'd0, a_i} * {32'd0, b_i};
  assign bZero       = (b_i == 32'd0);
  assign divOverflow = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

  // The most-negative / -1 case overflows; it is pinned to quotient = dividend, remainder 0.
  always_comb begin
    quotS = '0;
    remS  = '0;
    quotU = '0;
    remU  = '0;
    if (!bZero) begin
      if (divOverflow) begin
        quotS = aS;
        remS  = '0;
      end else begin
        quotS = aS / bS;
        remS  = aS % bS;
      end
      quotU = a_i / b_i;
      remU  = a_i % b_i;
    end
  end

  always_comb begin
    result_o      = '0;
    div_by_zero_o = 1'b0;
    case (op_i)
      OP_MULT:  result_o = $unsigned(prodS);
      OP_MULTU: result_o = prodU;
      OP_DIV: begin
        result_o      = {$unsigned(remS), $unsigned(quotS)};
        div_by_zero_o = bZero;
      end
      OP_DIVU: begin
        result_o      = {remU, quotU};
        div_by_zero_o = bZero;
      end
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// HI/LO multiply/divide sequencer: computes the result at issue, holds it in
// shadow registers for a fixed busy period, then commits to HI/LO.
module md_sequencer #(
  parameter int MULT_CYCLES = md_pkg::DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = md_pkg::DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic        start,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        id_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  import md_pkg::*;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [31:0]      shadowHi_q;
  logic [31:0]      shadowLo_q;
  logic             shadowDbz_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic             busy_q;

  logic [63:0]      aluResult;
  logic             aluDbz;
  logic             issueMd;
  logic             lastBusy;

  md_alu uAlu (
    .op_i          (op),
    .a_i           (src_a),
    .b_i           (src_b),
    .result_o      (aluResult),
    .div_by_zero_o (aluDbz)
  );

  assign issueMd  = start && isMultDiv(op);
  assign lastBusy = busy_q && (cnt_q == CNT_ONE);
  assign cnt_d    = isDiv(op) ? DIV_LOAD : MULT_LOAD;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shadowHi_q  <= '0;
      shadowLo_q  <= '0;
      shadowDbz_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issueMd) begin
            state_q     <= ST_BUSY;
            busy_q      <= 1'b1;
            cnt_q       <= cnt_d;
            shadowHi_q  <= aluResult[63:32];
            shadowLo_q  <= aluResult[31:0];
            shadowDbz_q <= aluDbz;
          end else if (start && (op == OP_MTHI)) begin
            hi_q <= src_a;
          end else if (start && (op == OP_MTLO)) begin
            lo_q <= src_a;
          end
        end
        // Any start seen while busy is dropped; the pipeline stall keeps it from happening.
        ST_BUSY: begin
          if (cnt_q == CNT_ONE) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            if (!shadowDbz_q) begin
              hi_q <= shadowHi_q;
              lo_q <= shadowLo_q;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
      endcase
    end
  end

  // The last busy cycle does not stall: the ID instruction reaches EX just as HI/LO commit.
  assign stall = id_md_use && ((busy_q && !lastBusy) || issueMd);
  assign busy  = busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
